// File: rtl/pio_mc_pkg.sv
// Shared register offsets and edge-mode encoding for the multi-channel PIO.
package pio_mc_pkg;

  localparam logic [2:0] REG_DATA_IN   = 3'd0;
  localparam logic [2:0] REG_DATA_OUT  = 3'd1;
  localparam logic [2:0] REG_OUT_SET   = 3'd2;
  localparam logic [2:0] REG_OUT_CLR   = 3'd3;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd4;
  localparam logic [2:0] REG_EDGE_CAP  = 3'd5;
  localparam logic [2:0] REG_EDGE_MODE = 3'd6;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;

endpackage

// File: rtl/pio_mc_channel.sv
// One PIO channel: input sampler, edge capture, output/mask/mode registers.
// Define PIO_MC_SYNC_EN to put a 2-flop synchroniser in front of the sampler.
module pio_mc_channel
  import pio_mc_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_pin,
  input  logic             i_wr,
  input  logic [2:0]       i_offset,
  input  logic [31:0]      i_wdata,
  output logic [WIDTH-1:0] o_pout,
  output logic [31:0]      o_rdata,
  output logic             o_irq_pending
);

  logic [WIDTH-1:0] r_sample;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  edge_mode_e       r_mode;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_cap_next;

  assign w_wd = i_wdata[WIDTH-1:0];

`ifdef PIO_MC_SYNC_EN
  logic [WIDTH-1:0] r_meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= '0;
      r_sample <= '0;
    end else begin
      r_meta   <= i_pin;
      r_sample <= r_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sample <= '0;
    else        r_sample <= i_pin;
  end
`endif

  always_comb begin
    w_edge = '0;
    case (r_mode)
      EDGE_RISE: w_edge = r_sample & ~r_prev;
      EDGE_FALL: w_edge = ~r_sample & r_prev;
      EDGE_BOTH: w_edge = r_sample ^ r_prev;
      default:   w_edge = '0;
    endcase
    w_clr = (i_wr && i_offset == REG_EDGE_CAP) ? w_wd : '0;
    // A new edge wins over a simultaneous write-1-to-clear.
    w_cap_next = (r_cap & ~w_clr) | w_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_out  <= OUT_RESET[WIDTH-1:0];
      r_mask <= '0;
      r_cap  <= '0;
      r_mode <= EDGE_OFF;
    end else begin
      r_prev <= r_sample;
      r_cap  <= w_cap_next;
      if (i_wr) begin
        case (i_offset)
          REG_DATA_OUT:  r_out  <= w_wd;
          REG_OUT_SET:   r_out  <= r_out | w_wd;
          REG_OUT_CLR:   r_out  <= r_out & ~w_wd;
          REG_IRQ_MASK:  r_mask <= w_wd;
          REG_EDGE_MODE: r_mode <= edge_mode_e'(i_wdata[1:0]);
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_offset)
      REG_DATA_IN:   o_rdata = 32'(r_sample);
      REG_DATA_OUT:  o_rdata = 32'(r_out);
      REG_IRQ_MASK:  o_rdata = 32'(r_mask);
      REG_EDGE_CAP:  o_rdata = 32'(r_cap);
      REG_EDGE_MODE: o_rdata = 32'(r_mode);
      default:       o_rdata = '0;
    endcase
  end

  assign o_pout        = r_out;
  assign o_irq_pending = |(r_cap & r_mask);

endmodule

// File: rtl/pio_mc.sv
// Multi-channel PIO behind an Avalon-MM slave: address decode, registered read
// path and interrupt. Input synchroniser is enabled by defining PIO_MC_SYNC_EN.
module pio_mc
  import pio_mc_pkg::*;
#(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [$clog2(CHANNELS)+2:0]   avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [31:0]                   avs_writedata,
  output logic [31:0]                   avs_readdata,
  output logic                          avs_readdatavalid,
  input  logic [CHANNELS*WIDTH-1:0]     pio_in,
  output logic [CHANNELS*WIDTH-1:0]     pio_out,
  output logic                          irq
);

  localparam int AW = $clog2(CHANNELS) + 3;

  logic [AW-1:0]       w_chan;
  logic                w_rd_acc;
  logic [CHANNELS-1:0] w_pend;
  logic [31:0]         w_rdata [CHANNELS];
  logic [31:0]         w_rd_mux;
  logic [31:0]         r_readdata;
  logic                r_rdv;
  logic                r_irq;

  assign w_chan   = avs_address >> 3;
  // A write beats a coincident read; the read is dropped entirely.
  assign w_rd_acc = avs_read & ~avs_write;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic w_sel;
      assign w_sel = (w_chan == AW'(gi));
      pio_mc_channel #(
        .WIDTH     (WIDTH),
        .OUT_RESET (OUT_RESET)
      ) u_ch (
        .clk           (clk_clk),
        .rst_n         (reset_reset_n),
        .i_pin         (pio_in[gi*WIDTH +: WIDTH]),
        .i_wr          (avs_write & w_sel),
        .i_offset      (avs_address[2:0]),
        .i_wdata       (avs_writedata),
        .o_pout        (pio_out[gi*WIDTH +: WIDTH]),
        .o_rdata       (w_rdata[gi]),
        .o_irq_pending (w_pend[gi])
      );
    end
  endgenerate

  // Out-of-range channel indices match nothing and read back as zero.
  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_chan == AW'(c)) w_rd_mux = w_rdata[c];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_readdata <= '0;
      r_rdv      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_rdv <= w_rd_acc;
      r_irq <= |w_pend;
      if (w_rd_acc) r_readdata <= w_rd_mux;
    end
  end

  assign avs_readdata      = r_readdata;
  assign avs_readdatavalid = r_rdv;
  assign irq               = r_irq;

endmodule

// File: tb/tb_pio_mc.sv
// Scoreboard bench for pio_mc (3 channels x 32 bits, OUT_RESET = 0xA5).
module tb_pio_mc;

  localparam int          CH  = 3;
  localparam int          W   = 32;
  localparam logic [31:0] ORV = 32'h0000_00A5;
  localparam int          AW  = $clog2(CH) + 3;
`ifdef PIO_MC_SYNC_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic [AW-1:0]     avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [CH*W-1:0]   pio_in;
  logic [CH*W-1:0]   pio_out;
  logic              irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  pio_mc #(.CHANNELS(CH), .WIDTH(W), .OUT_RESET(ORV)) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .pio_in            (pio_in),
    .pio_out           (pio_out),
    .irq               (irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wr(input int ch, input int off, input logic [31:0] d);
    avs_address   = AW'(ch * 8 + off);
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input int ch, input int off, input logic [31:0] exp, input string tag);
    avs_address = AW'(ch * 8 + off);
    avs_read    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    avs_read    = 1'b0;
  endtask

  // Read-response monitor: every valid beat must match the oldest expectation.
  always @(negedge clk_clk) begin
    if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("rdv_unexpected", 32'(avs_readdatavalid), 32'd0);
      end else begin
        check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    reset_reset_n = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    pio_in        = '0;
    repeat (3) step();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    reset_reset_n = 1'b1;
    step();

    for (int c = 0; c < CH; c++) begin
      check($sformatf("rst_pio_out%0d", c), pio_out[c*W +: W], ORV);
      for (int o = 0; o < 8; o++)
        rd(c, o, (o == 1) ? ORV : 32'd0, $sformatf("rst_rd_c%0d_o%0d", c, o));
    end

    // Output register with atomic set/clear.
    wr(1, 1, 32'hF0F0_0000);
    wr(1, 2, 32'h0000_000F);
    wr(1, 3, 32'hF000_0000);
    check("setclr_pio_out1", pio_out[1*W +: W], 32'h00F0_000F);
    check("setclr_pio_out0", pio_out[0*W +: W], ORV);
    rd(1, 1, 32'h00F0_000F, "setclr_rd_out1");
    rd(1, 2, 32'd0, "wo_set_reads0");

    // Rising edge on ch0 bit 0 with interrupt latency.
    wr(0, 6, 32'd1);
    wr(0, 4, 32'd1);
    pio_in[0] = 1'b1;
    step();
    repeat (L) step();
    check("rise_irq_k", 32'(irq), 32'd0);
    step();
    check("rise_irq_k1", 32'(irq), 32'd0);
    step();
    check("rise_irq_k2", 32'(irq), 32'd1);
    rd(0, 5, 32'd1, "rise_cap");
    rd(0, 0, 32'd1, "rise_data_in");
    wr(0, 5, 32'd1);
    check("w1c_irq_same_edge", 32'(irq), 32'd1);
    step();
    check("w1c_irq_next_edge", 32'(irq), 32'd0);
    rd(0, 5, 32'd0, "w1c_cap");

    // Falling edge on bit 3 coinciding with a W1C of that bit.
    wr(0, 6, 32'd2);
    pio_in[3] = 1'b1;
    repeat (4) step();
    rd(0, 5, 32'd0, "fall_no_rise_cap");
    pio_in[3] = 1'b0;
    step();
    repeat (L) step();
    wr(0, 5, 32'h8);
    rd(0, 5, 32'h8, "fall_set_wins");
    wr(0, 5, 32'h8);
    rd(0, 5, 32'd0, "fall_cleared");
    check("fall_irq_masked", 32'(irq), 32'd0);

    // Input capture on ch2.
    v = $urandom();
    pio_in[2*W +: W] = v;
    step();
    repeat (L) step();
    rd(2, 0, v, "data_in_ch2");

    // Out-of-range channel and simultaneous read/write.
    wr(3, 1, 32'hFFFF_FFFF);
    check("oor_wr_ch0", pio_out[0*W +: W], ORV);
    check("oor_wr_ch2", pio_out[2*W +: W], ORV);
    rd(3, 1, 32'd0, "oor_rd_out");
    rd(3, 0, 32'd0, "oor_rd_in");
    avs_address   = AW'(1 * 8 + 1);
    avs_writedata = 32'h1234_5678;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    step();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    check("rw_write_done", pio_out[1*W +: W], 32'h1234_5678);
    repeat (2) step();

    // Reset during an in-flight read with irq asserted.
    wr(0, 6, 32'd3);
    pio_in[0] = 1'b0;
    repeat (3 + L) step();
    check("both_irq", 32'(irq), 32'd1);
    avs_address = AW'(0 * 8 + 5);
    avs_read    = 1'b1;
    step();
    avs_read      = 1'b0;
    #1 reset_reset_n = 1'b0;
    #1;
    check("arst_rdv", 32'(avs_readdatavalid), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_pio_out1", pio_out[1*W +: W], ORV);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    step();
    rd(0, 5, 32'd0, "arst_cap");
    rd(0, 6, 32'd0, "arst_mode");
    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_mc.md
# pio_mc

Multi-channel parallel I/O peripheral: the parametrised successor to the single 32-bit in/out PIO pair in the SoC. It exposes CHANNELS independent WIDTH-bit ports behind one Avalon-MM slave on the PULPino master bus. Each channel has an input capture path with optional synchronisation, per-bit edge detection with a selectable mode, and a writable output register with atomic set/clear. The block raises a single level interrupt towards the core.

## Interface
- CHANNELS, 2: number of independent I/O channels (1..16).
- WIDTH, 32: bits per channel (1..32); register bits above WIDTH read 0, writes ignored.
- OUT_RESET, 0: reset value of every channel's output register.
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  $clog2(CHANNELS)+3  bits [2:0] select the register, upper bits select the channel.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- avs_readdatavalid  out  1  pulses one cycle after an accepted read.
- pio_in  in  CHANNELS*WIDTH  external inputs; channel c is bits [c*WIDTH +: WIDTH].
- pio_out  out  CHANNELS*WIDTH  external outputs, same packing.
- irq  out  1  level interrupt, registered.

## Operation
- Register map per channel (offset = avs_address[2:0]): 0 DATA_IN (RO); 1 DATA_OUT (RW); 2 OUT_SET (WO: DATA_OUT |= wdata); 3 OUT_CLR (WO: DATA_OUT &= ~wdata); 4 IRQ_MASK (RW); 5 EDGE_CAP (RW1C); 6 EDGE_MODE (RW, bits[1:0]: 0 off, 1 rising, 2 falling, 3 both); 7 reserved (reads 0, writes ignored). WO registers read 0.
- Channel index >= CHANNELS: writes ignored, reads return 0 with avs_readdatavalid still pulsed.
- Edge detect: compares the sampled input with its previous-cycle value; a matching transition sets the EDGE_CAP bit, which stays set until written 1.
- Simultaneous edge and W1C on the same bit: the set wins, and the bit stays 1.
- avs_read and avs_write asserted together: the write is performed and the read is ignored (no readdatavalid).
- irq = OR over all channels of |(EDGE_CAP & IRQ_MASK), registered.
- Reset values: pio_out = OUT_RESET replicated per channel; IRQ_MASK, EDGE_CAP, EDGE_MODE = 0; avs_readdata = 0; avs_readdatavalid = 0; irq = 0; sample and previous-sample registers = 0.
- The first edge comparison after reset sees previous = 0, so an input already high at reset generates a rising edge if enabled. Reset mid-operation clears all state immediately, with no pending read completion.

## Timing
- There is no wait state. A write takes effect on the clock edge where avs_write is high, and pio_out changes that same edge.
- Read latency is exactly 1. avs_readdata and avs_readdatavalid are valid the cycle after avs_read, and back-to-back reads are supported every cycle.
- Input change sampled at edge k:
  - With sync: DATA_IN updates at k+1, EDGE_CAP at k+2, irq at k+3.
  - Without sync: DATA_IN updates at k, EDGE_CAP at k+1, irq at k+2.
- A write to IRQ_MASK or EDGE_CAP affects irq one edge later.

## Configuration
- PIO_MC_SYNC_EN defined: every pio_in bit passes through a 2-flop synchroniser before DATA_IN and edge detection, which makes it safe for asynchronous pins.
- PIO_MC_SYNC_EN undefined: a single sample register only; inputs must be synchronous to clk_clk. Latencies are as given under Timing.

## Structure
- Package pio_mc_pkg holds the register offset localparams (REG_DATA_IN … REG_EDGE_MODE) and the edge-mode enum typedef (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
- Sub-module pio_mc_channel: one channel's synchroniser/sampler, edge detector, DATA_OUT, IRQ_MASK, EDGE_CAP and EDGE_MODE. It produces a per-channel irq_pending and a read mux.
- The top-level pio_mc instantiates CHANNELS copies in a generate loop and handles address decode, the readdata register and the irq OR.

## Test plan
- Reset with OUT_RESET=32'h0000_00A5 -> pio_out = 32'hA5 in every channel; all readbacks 0 except DATA_OUT = 32'hA5.
- Write DATA_OUT ch1 = 32'hF0F0_0000, then OUT_SET 32'h0000_000F, then OUT_CLR 32'hF000_0000 -> ch1 pio_out = 32'h00F0_000F; ch0 unchanged.
- ch0 EDGE_MODE=1, IRQ_MASK=32'h1; drive pio_in[0] 0->1 -> EDGE_CAP ch0 = 1 and irq high at the documented latency. Write EDGE_CAP 1 -> irq low the following edge.
- EDGE_MODE=2; drive bit 3 1->0 while writing EDGE_CAP=32'h8 in the capture cycle -> bit 3 remains set.
- Read address with channel index = CHANNELS (non-power-of-two config, CHANNELS=3) -> readdata 0 and readdatavalid pulses once.
- Assert reset_reset_n low mid-read with irq high -> readdatavalid, irq and EDGE_CAP cleared asynchronously; pio_out returns to OUT_RESET.
